// File: rtl/div_ctrl.sv
// Sequencing controller between the execute stage and the shared unsigned divider core.
// Converts signed operands to magnitudes, launches the core, and writes quotient/remainder to LO/HI.
//
// state  | meaning
// IDLE   | waiting for a request; ready when core is idle
// LAUNCH | one-cycle start pulse to the core
// ARM    | waiting (at most two cycles) for core busy to rise
// WAIT   | core running; capture q/r when busy falls
// FIXUP  | restore signs of quotient and remainder
// DONE   | one-cycle HI/LO write strobe
// DRAIN  | cancelled while core still running; hold off until it finishes
`timescale 1ns/1ps
module div_ctrl #(
   parameter int unsigned       DATA_W = 32,
   parameter logic [DATA_W-1:0] ZDIV_Q = 32'hFFFF_FFFF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_signed,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic              cancel,
   output logic              stall,
   output logic              div_start,
   output logic [DATA_W-1:0] div_dividend,
   output logic [DATA_W-1:0] div_divisor,
   input  logic              div_busy,
   input  logic [DATA_W-1:0] div_q,
   input  logic [DATA_W-1:0] div_r,
   output logic              hi_we,
   output logic              lo_we,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_ARM, S_WAIT, S_FIXUP, S_DONE, S_DRAIN
   } state_t;

   state_t            state;
   logic              arm_tmr;
   logic              neg_q;
   logic              neg_r;
   logic [DATA_W-1:0] q_cap;
   logic [DATA_W-1:0] r_cap;
   logic              cancellable;
   logic              core_live;

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
      return (sgn && x[DATA_W-1]) ? -x : x;
   endfunction

   assign req_ready   = (state == S_IDLE) && !div_busy;
   assign cancellable = (state == S_LAUNCH) || (state == S_ARM) ||
                        (state == S_WAIT)   || (state == S_FIXUP);
   // In LAUNCH/ARM the core has seen start but busy may not be visible yet.
   assign core_live   = div_busy || (state == S_LAUNCH) || (state == S_ARM);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         arm_tmr      <= 1'b0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         q_cap        <= '0;
         r_cap        <= '0;
         stall        <= 1'b0;
         div_start    <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
         hi_we        <= 1'b0;
         lo_we        <= 1'b0;
         hi_out       <= '0;
         lo_out       <= '0;
      end else begin
         div_start <= 1'b0;
         hi_we     <= 1'b0;
         lo_we     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && !div_busy && !cancel) begin
                  neg_q        <= req_signed & (req_a[DATA_W-1] ^ req_b[DATA_W-1]);
                  neg_r        <= req_signed & req_a[DATA_W-1];
                  div_dividend <= mag(req_a, req_signed);
                  div_divisor  <= mag(req_b, req_signed);
                  if (req_b == '0) begin
                     lo_out <= ZDIV_Q;
                     hi_out <= req_a;
                     hi_we  <= 1'b1;
                     lo_we  <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     div_start <= 1'b1;
                     stall     <= 1'b1;
                     state     <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               arm_tmr <= 1'b1;
               state   <= S_ARM;
            end
            S_ARM: begin
               if (div_busy || arm_tmr == 1'b0) state <= S_WAIT;
               else                             arm_tmr <= arm_tmr - 1'b1;
            end
            S_WAIT: begin
               if (!div_busy) begin
                  q_cap <= div_q;
                  r_cap <= div_r;
                  state <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               lo_out <= neg_q ? -q_cap : q_cap;
               hi_out <= neg_r ? -r_cap : r_cap;
               hi_we  <= 1'b1;
               lo_we  <= 1'b1;
               stall  <= 1'b0;
               state  <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            S_DRAIN: if (!div_busy) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         // A flush abandons the operation; a committed write in DONE is not cancellable.
         if (cancel && cancellable) begin
            state     <= core_live ? S_DRAIN : S_IDLE;
            stall     <= 1'b0;
            div_start <= 1'b0;
            hi_we     <= 1'b0;
            lo_we     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: behavioural divider core plus a plain-arithmetic
// reference for the expected LO/HI values and strobe timing.
`timescale 1ns/1ps
module tb_div_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_signed, cancel;
   logic [31:0] req_a, req_b;
   logic        stall, div_start, div_busy, hi_we, lo_we;
   logic [31:0] div_dividend, div_divisor, div_q, div_r, hi_out, lo_out;

   int tests = 0;
   int fails = 0;

   int          core_lat  = 32;
   bit          core_skew = 1'b0;
   int          core_cnt;
   bit          core_pend;
   logic [31:0] res_q, res_r;

   div_ctrl #(.DATA_W(32), .ZDIV_Q(32'hFFFF_FFFF)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
      .req_a(req_a), .req_b(req_b), .cancel(cancel), .stall(stall),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_busy(div_busy), .div_q(div_q), .div_r(div_r),
      .hi_we(hi_we), .lo_we(lo_we), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clock = ~clock;

   // Divider core: busy for core_lat cycles (optionally one cycle late), junk on q/r while busy.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         div_busy  <= 1'b0;
         core_cnt  <= 0;
         core_pend <= 1'b0;
         div_q     <= '0;
         div_r     <= '0;
         res_q     <= '0;
         res_r     <= '0;
      end else if (div_start && !div_busy && !core_pend) begin
         res_q    <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
         res_r    <= (div_divisor == 0) ? div_dividend  : div_dividend % div_divisor;
         core_cnt <= core_lat;
         if (core_skew) core_pend <= 1'b1;
         else           div_busy  <= 1'b1;
      end else if (core_pend) begin
         core_pend <= 1'b0;
         div_busy  <= 1'b1;
      end else if (div_busy) begin
         core_cnt <= core_cnt - 1;
         div_q    <= $urandom;
         div_r    <= $urandom;
         if (core_cnt == 1) begin
            div_busy <= 1'b0;
            div_q    <= res_q;
            div_r    <= res_r;
         end
      end
   end

   function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] lo, output logic [31:0] hi);
      if (b == 0) begin
         lo = 32'hFFFF_FFFF;
         hi = a;
      end else if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'h0;
         end else begin
            lo = $signed(a) / $signed(b);
            hi = $signed(a) % $signed(b);
         end
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endfunction

   task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input bit skew, input bit hold);
      logic [31:0] exp_lo, exp_hi;
      int cyc, starts, exp_lat;
      bit stall_ok, got;
      ref_div(sgn, a, b, exp_lo, exp_hi);
      exp_lat   = (b == 0) ? 1 : lat + 4 + int'(skew);
      core_lat  = lat;
      core_skew = skew;
      cyc = 0;
      while (!req_ready && cyc < 200) begin @(negedge clock); cyc++; end
      tests++;
      if (req_ready !== 1'b1) begin
         $display("FAIL %s ready_wait: got %b expected 1", name, req_ready); fails++; return;
      end
      req_valid = 1'b1; req_signed = sgn; req_a = a; req_b = b;
      @(negedge clock);
      if (!hold) req_valid = 1'b0;
      starts = 0; stall_ok = 1'b1; got = 1'b0; cyc = 1;
      while (!got && cyc <= 200) begin
         if (div_start === 1'b1) starts++;
         if (hi_we === 1'b1) got = 1'b1;
         else begin
            if (stall !== (b != 0)) stall_ok = 1'b0;
            @(negedge clock);
            cyc++;
         end
      end
      req_valid = 1'b0;
      tests++;
      if (!got) begin
         $display("FAIL %s strobe_timeout: no hi_we within 200 cycles", name); fails++; return;
      end
      tests++;
      if (cyc != exp_lat) begin
         $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat); fails++;
      end
      tests++;
      if (lo_we !== 1'b1) begin $display("FAIL %s lo_we: got %b expected 1", name, lo_we); fails++; end
      tests++;
      if (lo_out !== exp_lo) begin
         $display("FAIL %s lo_out: got %h expected %h", name, lo_out, exp_lo); fails++;
      end
      tests++;
      if (hi_out !== exp_hi) begin
         $display("FAIL %s hi_out: got %h expected %h", name, hi_out, exp_hi); fails++;
      end
      tests++;
      if (stall !== 1'b0) begin $display("FAIL %s stall_in_done: got %b expected 0", name, stall); fails++; end
      tests++;
      if (starts != ((b != 0) ? 1 : 0)) begin
         $display("FAIL %s start_pulses: got %0d expected %0d", name, starts, (b != 0) ? 1 : 0); fails++;
      end
      tests++;
      if (!stall_ok) begin $display("FAIL %s stall_profile: stall wrong before strobe", name); fails++; end
      @(negedge clock);
      tests++;
      if ({hi_we, lo_we} !== 2'b00) begin
         $display("FAIL %s strobe_width: got %b%b expected 00", name, hi_we, lo_we); fails++;
      end
   endtask

   task automatic check_reset_values(input string name);
      tests++;
      if ({stall, div_start, hi_we, lo_we, hi_out, lo_out, div_dividend, div_divisor} !== '0) begin
         $display("FAIL %s outputs: got stall=%b start=%b we=%b%b hi=%h lo=%h dd=%h dv=%h expected all 0",
                  name, stall, div_start, hi_we, lo_we, hi_out, lo_out, div_dividend, div_divisor);
         fails++;
      end
      tests++;
      if (req_ready !== 1'b1) begin $display("FAIL %s req_ready: got %b expected 1", name, req_ready); fails++; end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0; cancel = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_values("reset");
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_directed();
      run_op("divu_100_7",  1'b0, 32'd100,        32'd7,          32, 1'b0, 1'b0);
      run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32, 1'b0, 1'b0);
      run_op("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32, 1'b0, 1'b0);
      run_op("divu_5_0",    1'b0, 32'd5,          32'd0,          32, 1'b0, 1'b0);
      run_op("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32, 1'b0, 1'b0);
      run_op("div_skew",    1'b1, 32'h8000_0001,  32'd10,         12, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_op("held_req",    1'b0, 32'd1000,       32'd33,         20, 1'b0, 1'b1);
      run_op("next_req",    1'b1, 32'hFFFF_FC18,  32'hFFFF_FFDF,  20, 1'b0, 1'b0);
   endtask

   task automatic test_cancel();
      int cyc;
      bit ready_ok, quiet_ok;
      core_lat = 32; core_skew = 1'b0;
      cyc = 0;
      while (!req_ready && cyc < 100) begin @(negedge clock); cyc++; end
      req_valid = 1'b1; req_signed = 1'b0; req_a = 32'hFFFF_FFFF; req_b = 32'd3;
      @(negedge clock);
      req_valid = 1'b0;
      repeat (12) @(negedge clock);
      cancel = 1'b1;
      @(negedge clock);
      cancel = 1'b0;
      tests++;
      if (stall !== 1'b0) begin $display("FAIL cancel_stall: got %b expected 0", stall); fails++; end
      tests++;
      if ({hi_we, lo_we} !== 2'b00) begin
         $display("FAIL cancel_no_write: got %b%b expected 00", hi_we, lo_we); fails++;
      end
      // Offer a request during the drain; it must not be taken.
      req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd9; req_b = 32'd3;
      ready_ok = 1'b1; quiet_ok = 1'b1; cyc = 0;
      while (div_busy === 1'b1 && cyc < 100) begin
         if (req_ready !== 1'b0) ready_ok = 1'b0;
         if (hi_we !== 1'b0 || div_start !== 1'b0 || stall !== 1'b0) quiet_ok = 1'b0;
         @(negedge clock);
         cyc++;
      end
      req_valid = 1'b0;
      tests++;
      if (div_busy !== 1'b0) begin $display("FAIL cancel_drain_timeout: busy still %b", div_busy); fails++; end
      tests++;
      if (!ready_ok) begin $display("FAIL cancel_ready_held: req_ready rose while core busy, expected 0"); fails++; end
      tests++;
      if (!quiet_ok) begin $display("FAIL cancel_quiet: write/start/stall seen during drain, expected none"); fails++; end
      run_op("after_cancel", 1'b0, 32'd9, 32'd3, 32, 1'b0, 1'b0);
   endtask

   task automatic test_cancel_idle();
      req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd50; req_b = 32'd5; cancel = 1'b1;
      @(negedge clock);
      req_valid = 1'b0; cancel = 1'b0;
      @(negedge clock);
      tests++;
      if ({stall, div_start, hi_we} !== 3'b000) begin
         $display("FAIL cancel_idle_accept: got stall=%b start=%b hi_we=%b expected 000", stall, div_start, hi_we);
         fails++;
      end
   endtask

   task automatic test_reset_mid();
      core_lat = 32; core_skew = 1'b0;
      req_valid = 1'b1; req_signed = 1'b1; req_a = 32'hF000_0000; req_b = 32'd7;
      @(negedge clock);
      req_valid = 1'b0;
      repeat (12) @(negedge clock);
      #2 reset = 1'b1;
      #1 check_reset_values("reset_mid");
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_op("after_reset", 1'b0, 32'd1, 32'd1, 32, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         logic        sgn;
         logic [31:0] a, b;
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         b   = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'($urandom_range(1, 16));
            4: b = -32'($urandom_range(1, 16));
            default: ;
         endcase
         run_op("random", sgn, a, b, int'($urandom_range(2, 40)), 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_cancel();
      test_cancel_idle();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
